// File: rtl/test_oled.sv
// test_oled: self-running SSD1306 128x32 power-up, init and test-frame SPI driver
module test_oled #(
  parameter int CLK_DIV = 4,
  parameter int T_VDD   = 41667,
  parameter int T_RES   = 125,
  parameter int T_VBAT  = 4166667,
  parameter int NBYTES  = 512
) (
  input  logic clock,
  input  logic reset,
  output logic out_oled_vdd,
  output logic out_oled_reset,
  output logic out_oled_clk,
  output logic out_oled_vbat,
  output logic out_oled_dout,
  output logic out_oled_isData,
  output logic out_oled_debug
);
  typedef enum logic [3:0] {
    PWR_OFF, VDD_ON, CMD0, RES_LO, RES_HI, CMD1, VBAT_ON, CMD2, FRAME, FRAME_GAP
  } state_t;
  // Whole init command list; CMD0/CMD1/CMD2 end at indices 0, 4 and 13.
  localparam logic [7:0] CMDS [16] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F, 8'hA1,
                                       8'hC8, 8'hDA, 8'h20, 8'h20, 8'h00, 8'hAF, 8'h00, 8'h00};
  state_t      state_q, state_d;
  logic [22:0] dly_q, dly_d, lim;
  logic [9:0]  idx_q, idx_d;
  logic [4:0]  hp_q, hp_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  byte_q, byte_d, cur_byte;
  logic [2:0]  bit_sel;
  logic        vdd_q, vdd_d, vbat_q, vbat_d, res_q, res_d;
  logic        sclk_q, sclk_d, dout_q, dout_d, dc_q, dc_d, dbg_q, dbg_d;
  logic        send, bdone, last, wait_done;
  // Sequencer, delay timer and byte shifter; hp counts half-periods, 0 = the idle/setup clock.
  always_comb begin
    send      = state_q inside {CMD0, CMD1, CMD2, FRAME};
    bdone     = send && hp_q == 5'd16 && div_q == 8'(CLK_DIV - 1);
    last      = state_q == CMD0 ? idx_q == 10'd0 :
                state_q == CMD1 ? idx_q == 10'd4 :
                state_q == CMD2 ? idx_q == 10'd13 : idx_q == 10'(NBYTES - 1);
    lim       = state_q == VDD_ON ? 23'(T_VDD) : state_q == VBAT_ON ? 23'(T_VBAT) : 23'(T_RES);
    wait_done = dly_q == lim - 23'd1;
    cur_byte  = state_q == FRAME ? idx_q[7:0] ^ {idx_q[9:7], 5'b0} : CMDS[idx_q[3:0]];
    state_d   = state_q;
    dly_d     = dly_q + 23'd1;
    idx_d     = idx_q;
    hp_d      = hp_q;
    div_d     = div_q;
    byte_d    = byte_q;
    case (state_q)
      PWR_OFF:   state_d = VDD_ON;
      VDD_ON:    state_d = wait_done ? CMD0 : state_q;
      RES_LO:    state_d = wait_done ? RES_HI : state_q;
      RES_HI:    state_d = wait_done ? CMD1 : state_q;
      VBAT_ON:   state_d = wait_done ? CMD2 : state_q;
      FRAME_GAP: state_d = FRAME;
      default:   state_d = !(bdone && last) ? state_q :
                           state_q == CMD0 ? RES_LO :
                           state_q == CMD1 ? VBAT_ON :
                           state_q == CMD2 ? FRAME : FRAME_GAP;
    endcase
    if (state_d != state_q) dly_d = '0;
    if (send) begin
      if (hp_q == 5'd0) begin
        hp_d   = 5'd1;
        div_d  = '0;
        byte_d = cur_byte;
      end else if (div_q == 8'(CLK_DIV - 1)) begin
        div_d = '0;
        hp_d  = bdone ? 5'd0 : hp_q + 5'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
    if (bdone) idx_d = (last && state_q inside {CMD2, FRAME}) ? 10'd0 : idx_q + 10'd1;
    bit_sel = 3'((hp_d - 5'd1) >> 1);
    sclk_d  = hp_d == 5'd0 || !hp_d[0];
    dout_d  = hp_d != 5'd0 && byte_d[~bit_sel];
    dc_d    = state_d inside {FRAME, FRAME_GAP};
    vdd_d   = vdd_q && state_d != VDD_ON;
    vbat_d  = vbat_q && state_d != VBAT_ON;
    res_d   = state_d != RES_LO;
    dbg_d   = dbg_q || (bdone && last && state_q == CMD2);
  end
  // State and registered panel outputs; reset drops everything back to power-off at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= PWR_OFF;
      dly_q   <= '0;
      idx_q   <= '0;
      hp_q    <= '0;
      div_q   <= '0;
      byte_q  <= '0;
      vdd_q   <= 1'b1;
      vbat_q  <= 1'b1;
      res_q   <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= 1'b0;
      dc_q    <= 1'b0;
      dbg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      hp_q    <= hp_d;
      div_q   <= div_d;
      byte_q  <= byte_d;
      vdd_q   <= vdd_d;
      vbat_q  <= vbat_d;
      res_q   <= res_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
      dc_q    <= dc_d;
      dbg_q   <= dbg_d;
    end
  end
  assign out_oled_vdd    = vdd_q;
  assign out_oled_vbat   = vbat_q;
  assign out_oled_reset  = res_q;
  assign out_oled_clk    = sclk_q;
  assign out_oled_dout   = dout_q;
  assign out_oled_isData = dc_q;
  assign out_oled_debug  = dbg_q;
endmodule

// File: tb/tb_test_oled.sv
// tb_test_oled: decodes the SPI stream and power sequencing of test_oled against directed expectations
module tb_test_oled;
  logic clock = 1'b0, reset = 1'b0;
  logic vdd, res, sclk, vbat, dout, dc, dbg;
  int vectors = 0, miscompares = 0;
  int got_byte[$], got_dc[$];
  int cyc = 0, nb = 0, cur_dc = 0, dc_bad = 0;
  int vdd_fall = -1, first_edge = -1, res_fall = -1, res_fall_n = -1, res_rise = -1;
  int vbat_fall = -1, vbat_n = -1, post_vbat = -1, dbg_n = -1;
  logic [7:0] sh = '0;
  logic sclk_p = 1'b1, vdd_p = 1'b1, res_p = 1'b1, vbat_p = 1'b1, dbg_p = 1'b0;
  logic [7:0] exp_cmd [14] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F,
                               8'hA1, 8'hC8, 8'hDA, 8'h20, 8'h20, 8'h00, 8'hAF};

  test_oled #(.CLK_DIV(2), .T_VDD(10), .T_RES(4), .T_VBAT(20), .NBYTES(8)) dut (
    .clock(clock), .reset(reset), .out_oled_vdd(vdd), .out_oled_reset(res),
    .out_oled_clk(sclk), .out_oled_vbat(vbat), .out_oled_dout(dout),
    .out_oled_isData(dc), .out_oled_debug(dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (got_byte.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("byte_wait_timeout", int'(got_byte.size() >= n), 1);
  endtask

  // SPI/power monitor sampled on the falling system-clock edge
  always @(negedge clock) begin
    if (!reset) begin
      cyc = 0; nb = 0; sclk_p = 1'b1; vdd_p = 1'b1; res_p = 1'b1; vbat_p = 1'b1; dbg_p = 1'b0;
    end else begin
      cyc++;
      if (vdd_p && !vdd) vdd_fall = cyc;
      if (sclk != sclk_p && first_edge < 0) first_edge = cyc;
      if (res_p && !res) begin res_fall = cyc; res_fall_n = got_byte.size(); end
      if (!res_p && res) res_rise = cyc;
      if (vbat_p && !vbat) begin vbat_fall = cyc; vbat_n = got_byte.size(); end
      if (vbat_fall >= 0 && post_vbat < 0 && sclk != sclk_p && cyc > vbat_fall) post_vbat = cyc;
      if (!dbg_p && dbg) dbg_n = got_byte.size();
      if (!sclk_p && sclk) begin
        if (nb == 0) cur_dc = int'(dc);
        else if (int'(dc) != cur_dc) dc_bad = 1;
        sh = {sh[6:0], dout};
        nb++;
        if (nb == 8) begin
          got_byte.push_back(int'(sh));
          got_dc.push_back(cur_dc);
          nb = 0;
        end
      end
      sclk_p = sclk; vdd_p = vdd; res_p = res; vbat_p = vbat; dbg_p = dbg;
    end
  end

  initial begin
    int mark;
    repeat (3) @(negedge clock);
    chk("rst_vdd", int'(vdd), 1);
    chk("rst_vbat", int'(vbat), 1);
    chk("rst_res", int'(res), 1);
    chk("rst_sclk", int'(sclk), 1);
    chk("rst_isdata", int'(dc), 0);
    chk("rst_debug", int'(dbg), 0);
    #1 reset = 1'b1;
    wait_bytes(30, 3000);
    chk("vdd_fall_cycle", int'(vdd_fall >= 1 && vdd_fall <= 2), 1);
    chk("vdd_quiet_10clk", int'(first_edge - vdd_fall >= 10 && first_edge - vdd_fall <= 12), 1);
    chk("res_after_0xAE", res_fall_n, 1);
    chk("res_low_len", res_rise - res_fall, 4);
    chk("vbat_after_0xF1", vbat_n, 5);
    chk("vbat_quiet_20clk", int'(post_vbat - vbat_fall >= 20 && post_vbat - vbat_fall <= 22), 1);
    chk("debug_after_0xAF", dbg_n, 14);
    chk("dc_stable_in_byte", dc_bad, 0);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("cmd%0d", i), got_byte[i], int'(exp_cmd[i]));
      chk($sformatf("cmd%0d_dc", i), got_dc[i], 0);
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("data%0d", i), got_byte[14 + i], i % 8);
      chk($sformatf("data%0d_dc", i), got_dc[14 + i], 1);
    end
    chk("debug_sticky", int'(dbg), 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_vdd", int'(vdd), 1);
    chk("mid_rst_vbat", int'(vbat), 1);
    chk("mid_rst_debug", int'(dbg), 0);
    chk("mid_rst_isdata", int'(dc), 0);
    chk("mid_rst_sclk", int'(sclk), 1);
    repeat (2) @(negedge clock);
    mark = got_byte.size();
    #1 reset = 1'b1;
    wait_bytes(mark + 1, 500);
    if (got_byte.size() > mark) begin
      chk("restart_byte", got_byte[mark], 8'hAE);
      chk("restart_dc", got_dc[mark], 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
